// File: rtl/mem_arbiter.sv
// Two-port arbiter for one synchronous 32-bit memory port with per-port lock ownership.
// Optional starvation guard for port 1 is enabled by defining MEM_ARB_STARVE_EN.
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              we0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              pend0_q, pend1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              starve_force;

`ifdef MEM_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_q;

    assign starve_force = (starve_q == CNT_W'(STARVE_LIMIT));

    // Counts IDLE cycles where port 1 waits; saturates so the forced grant stays armed.
    always_ff @(posedge clock) begin
        if (reset)
            starve_q <= '0;
        else if (gnt1)
            starve_q <= '0;
        else if (owner_q == IDLE && req1 && !starve_force)
            starve_q <= starve_q + 1'b1;
    end
`else
    assign starve_force = 1'b0;
`endif

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        owner_d = owner_q;
        if (!reset) begin
            unique case (owner_q)
                IDLE: begin
                    if (req1 && starve_force) gnt1 = 1'b1;
                    else if (req0)            gnt0 = 1'b1;
                    else if (req1)            gnt1 = 1'b1;
                    if (gnt0 && lock0)        owner_d = OWN0;
                    else if (gnt1 && lock1)   owner_d = OWN1;
                end
                OWN0: begin
                    gnt0 = req0;
                    if (!lock0) owner_d = IDLE;
                end
                OWN1: begin
                    gnt1 = req1;
                    if (!lock1) owner_d = IDLE;
                end
                default: owner_d = IDLE;
            endcase
        end
    end

    // With no grant the address and data hold their last issued values.
    always_comb begin
        mem_we    = (gnt0 && we0) || (gnt1 && we1);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (reset) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (gnt0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            pend0_q  <= 1'b0;
            pend1_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            owner_q <= owner_d;
            if (gnt0 || gnt1) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            pend0_q <= gnt0 && !we0;
            pend1_q <= gnt1 && !we1;
            if (pend0_q) rdata0_q <= mem_rdata;
            if (pend1_q) rdata1_q <= mem_rdata;
        end
    end

    // Read data passes straight through in its valid cycle; reset suppresses an in-flight return.
    assign rvalid0 = pend0_q && !reset;
    assign rvalid1 = pend1_q && !reset;
    assign rdata0  = reset ? '0 : (pend0_q ? mem_rdata : rdata0_q);
    assign rdata1  = reset ? '0 : (pend1_q ? mem_rdata : rdata1_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural synchronous memory.
// Define MEM_ARB_STARVE_EN for both RTL and bench to check the starvation guard.
module tb_mem_arbiter;

    logic        clock, reset;
    logic        req0, lock0, we0, gnt0, rvalid0;
    logic [15:0] addr0;
    logic [31:0] wdata0, rdata0;
    logic        req1, lock1, we1, gnt1, rvalid1;
    logic [15:0] addr1;
    logic [31:0] wdata1, rdata1;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [0:65535];
    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .lock0(lock0), .addr0(addr0), .we0(we0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .lock1(lock1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous memory: write on the edge, read data valid the cycle after the address.
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; lock0 = 0; addr0 = '0; we0 = 0; wdata0 = '0;
        req1 = 0; lock1 = 0; addr1 = '0; we1 = 0; wdata1 = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        req0 = 1; we0 = 1; addr0 = 16'h1234; wdata0 = 32'hCAFEF00D;
        req1 = 1;
        @(negedge clock);
        if (gnt0 !== 1'b0) begin $display("FAIL rst_gnt0: got %b want 0", gnt0); n_bad++; end n_cmp++;
        if (gnt1 !== 1'b0) begin $display("FAIL rst_gnt1: got %b want 0", gnt1); n_bad++; end n_cmp++;
        if (mem_we !== 1'b0) begin $display("FAIL rst_mem_we: got %b want 0", mem_we); n_bad++; end n_cmp++;
        if (mem_addr !== 16'h0) begin $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); n_bad++; end n_cmp++;
        if (mem_wdata !== 32'h0) begin $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); n_bad++; end n_cmp++;
        tick();
        @(negedge clock);
        if (rvalid0 !== 1'b0) begin $display("FAIL rst_rvalid0: got %b want 0", rvalid0); n_bad++; end n_cmp++;
        if (rvalid1 !== 1'b0) begin $display("FAIL rst_rvalid1: got %b want 0", rvalid1); n_bad++; end n_cmp++;
        if (rdata0 !== 32'h0) begin $display("FAIL rst_rdata0: got %h want 0", rdata0); n_bad++; end n_cmp++;
        if (rdata1 !== 32'h0) begin $display("FAIL rst_rdata1: got %h want 0", rdata1); n_bad++; end n_cmp++;
        clear_inputs();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        req0 = 1; we0 = 1; addr0 = 16'h0010; wdata0 = 32'hDEADBEEF;
        @(negedge clock);
        if (gnt0 !== 1'b1) begin $display("FAIL wr_gnt0: got %b want 1", gnt0); n_bad++; end n_cmp++;
        if (mem_we !== 1'b1) begin $display("FAIL wr_mem_we: got %b want 1", mem_we); n_bad++; end n_cmp++;
        if (mem_addr !== 16'h0010) begin $display("FAIL wr_mem_addr: got %h want 0010", mem_addr); n_bad++; end n_cmp++;
        if (mem_wdata !== 32'hDEADBEEF) begin $display("FAIL wr_mem_wdata: got %h want deadbeef", mem_wdata); n_bad++; end n_cmp++;
        tick();
        we0 = 0; wdata0 = '0;
        @(negedge clock);
        if (gnt0 !== 1'b1) begin $display("FAIL rd_gnt0: got %b want 1", gnt0); n_bad++; end n_cmp++;
        if (mem_we !== 1'b0) begin $display("FAIL rd_mem_we: got %b want 0", mem_we); n_bad++; end n_cmp++;
        if (rvalid0 !== 1'b0) begin $display("FAIL wr_no_rvalid0: got %b want 0", rvalid0); n_bad++; end n_cmp++;
        tick();
        clear_inputs();
        @(negedge clock);
        if (rvalid0 !== 1'b1) begin $display("FAIL rd_rvalid0: got %b want 1", rvalid0); n_bad++; end n_cmp++;
        if (rdata0 !== 32'hDEADBEEF) begin $display("FAIL rd_rdata0: got %h want deadbeef", rdata0); n_bad++; end n_cmp++;
        if (rvalid1 !== 1'b0) begin $display("FAIL rd_rvalid1: got %b want 0", rvalid1); n_bad++; end n_cmp++;
        if (mem_addr !== 16'h0010) begin $display("FAIL idle_mem_addr_hold: got %h want 0010", mem_addr); n_bad++; end n_cmp++;
        if (mem_we !== 1'b0) begin $display("FAIL idle_mem_we: got %b want 0", mem_we); n_bad++; end n_cmp++;
        tick();
        @(negedge clock);
        if (rvalid0 !== 1'b0) begin $display("FAIL rd_pulse_end: got %b want 0", rvalid0); n_bad++; end n_cmp++;
        if (rdata0 !== 32'hDEADBEEF) begin $display("FAIL rd_rdata0_held: got %h want deadbeef", rdata0); n_bad++; end n_cmp++;
        tick();
    endtask

    task automatic test_simultaneous();
        req0 = 1; addr0 = 16'h0001;
        req1 = 1; addr1 = 16'h0002;
        @(negedge clock);
        if (gnt0 !== 1'b1) begin $display("FAIL sim_n_gnt0: got %b want 1", gnt0); n_bad++; end n_cmp++;
        if (gnt1 !== 1'b0) begin $display("FAIL sim_n_gnt1: got %b want 0", gnt1); n_bad++; end n_cmp++;
        tick();
        req0 = 0; addr0 = '0;
        @(negedge clock);
        if (gnt1 !== 1'b1) begin $display("FAIL sim_n1_gnt1: got %b want 1", gnt1); n_bad++; end n_cmp++;
        if (mem_addr !== 16'h0002) begin $display("FAIL sim_n1_mem_addr: got %h want 0002", mem_addr); n_bad++; end n_cmp++;
        if (rvalid0 !== 1'b1) begin $display("FAIL sim_n1_rvalid0: got %b want 1", rvalid0); n_bad++; end n_cmp++;
        if (rdata0 !== 32'h11111111) begin $display("FAIL sim_n1_rdata0: got %h want 11111111", rdata0); n_bad++; end n_cmp++;
        tick();
        clear_inputs();
        @(negedge clock);
        if (rvalid1 !== 1'b1) begin $display("FAIL sim_n2_rvalid1: got %b want 1", rvalid1); n_bad++; end n_cmp++;
        if (rdata1 !== 32'h22222222) begin $display("FAIL sim_n2_rdata1: got %h want 22222222", rdata1); n_bad++; end n_cmp++;
        if (rvalid0 !== 1'b0) begin $display("FAIL sim_n2_rvalid0: got %b want 0", rvalid0); n_bad++; end n_cmp++;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        req0 = 1; addr0 = 16'h0001;
        tick();
        addr0 = 16'h0002;
        @(negedge clock);
        if (gnt0 !== 1'b1) begin $display("FAIL b2b_gnt0: got %b want 1", gnt0); n_bad++; end n_cmp++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'h11111111) begin
            $display("FAIL b2b_first: got %b/%h want 1/11111111", rvalid0, rdata0); n_bad++;
        end n_cmp++;
        tick();
        clear_inputs();
        @(negedge clock);
        if (rvalid0 !== 1'b1 || rdata0 !== 32'h22222222) begin
            $display("FAIL b2b_second: got %b/%h want 1/22222222", rvalid0, rdata0); n_bad++;
        end n_cmp++;
        tick();
        @(negedge clock);
        if (rvalid0 !== 1'b0) begin $display("FAIL b2b_end: got %b want 0", rvalid0); n_bad++; end n_cmp++;
        tick();
    endtask

    task automatic test_lock();
        req1 = 1; lock1 = 1; addr1 = 16'h0020;
        @(negedge clock);
        if (gnt1 !== 1'b1) begin $display("FAIL lk_c1_gnt1: got %b want 1", gnt1); n_bad++; end n_cmp++;
        tick();
        req0 = 1; addr0 = 16'h0030; addr1 = 16'h0021;
        @(negedge clock);
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            $display("FAIL lk_c2_gnt: got gnt0=%b gnt1=%b want 0/1", gnt0, gnt1); n_bad++;
        end n_cmp++;
        tick();
        req1 = 0;
        @(negedge clock);
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            $display("FAIL lk_c3_held: got gnt0=%b gnt1=%b want 0/0", gnt0, gnt1); n_bad++;
        end n_cmp++;
        tick();
        lock1 = 0;
        @(negedge clock);
        if (gnt0 !== 1'b0) begin $display("FAIL lk_c4_release_edge: got %b want 0", gnt0); n_bad++; end n_cmp++;
        tick();
        @(negedge clock);
        if (gnt0 !== 1'b1) begin $display("FAIL lk_c5_gnt0: got %b want 1", gnt0); n_bad++; end n_cmp++;
        if (mem_addr !== 16'h0030) begin $display("FAIL lk_c5_mem_addr: got %h want 0030", mem_addr); n_bad++; end n_cmp++;
        tick();
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        req0 = 1; lock0 = 1; addr0 = 16'h0010;
        @(negedge clock);
        if (gnt0 !== 1'b1) begin $display("FAIL rm_gnt0: got %b want 1", gnt0); n_bad++; end n_cmp++;
        tick();
        reset = 1; req0 = 0; req1 = 1; addr1 = 16'h0050;
        @(negedge clock);
        if (rvalid0 !== 1'b0) begin $display("FAIL rm_rvalid0_suppressed: got %b want 0", rvalid0); n_bad++; end n_cmp++;
        if (gnt1 !== 1'b0) begin $display("FAIL rm_gnt1_in_reset: got %b want 0", gnt1); n_bad++; end n_cmp++;
        if (mem_we !== 1'b0) begin $display("FAIL rm_mem_we: got %b want 0", mem_we); n_bad++; end n_cmp++;
        if (mem_addr !== 16'h0) begin $display("FAIL rm_mem_addr: got %h want 0000", mem_addr); n_bad++; end n_cmp++;
        tick();
        reset = 0;
        @(negedge clock);
        if (gnt1 !== 1'b1) begin $display("FAIL rm_owner_idle_gnt1: got %b want 1", gnt1); n_bad++; end n_cmp++;
        if (rvalid0 !== 1'b0) begin $display("FAIL rm_rvalid0_after: got %b want 0", rvalid0); n_bad++; end n_cmp++;
        tick();
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_starvation();
        logic exp0, exp1;
        req0 = 1; addr0 = 16'h0040;
        req1 = 1; addr1 = 16'h0041;
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_STARVE_EN
            exp1 = (i % 5 == 4);
`else
            exp1 = 1'b0;
`endif
            exp0 = !exp1;
            @(negedge clock);
            if (gnt0 !== exp0 || gnt1 !== exp1) begin
                $display("FAIL starve_cycle%0d: got gnt0=%b gnt1=%b want %b/%b", i, gnt0, gnt1, exp0, exp1);
                n_bad++;
            end
            n_cmp++;
            tick();
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_max_addr();
        req1 = 1; addr1 = 16'hFFFF;
        @(negedge clock);
        if (gnt1 !== 1'b1) begin $display("FAIL max_gnt1: got %b want 1", gnt1); n_bad++; end n_cmp++;
        if (mem_addr !== 16'hFFFF) begin $display("FAIL max_mem_addr: got %h want ffff", mem_addr); n_bad++; end n_cmp++;
        tick();
        clear_inputs();
        @(negedge clock);
        if (rvalid1 !== 1'b1) begin $display("FAIL max_rvalid1: got %b want 1", rvalid1); n_bad++; end n_cmp++;
        if (rdata1 !== 32'hA5A55A5A) begin $display("FAIL max_rdata1: got %h want a5a55a5a", rdata1); n_bad++; end n_cmp++;
        if (rvalid0 !== 1'b0) begin $display("FAIL max_rvalid0: got %b want 0", rvalid0); n_bad++; end n_cmp++;
        tick();
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
        mem[16'h0001] = 32'h11111111;
        mem[16'h0002] = 32'h22222222;
        mem[16'hFFFF] = 32'hA5A55A5A;
        reset = 1'b1;
        clear_inputs();
        #1;
        test_reset();
        test_write_read();
        test_simultaneous();
        test_back_to_back();
        test_lock();
        test_reset_mid();
        test_starvation();
        test_max_addr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
